ro_cache_refill_ctrl: RTL

// Line-refill sequencer for the read-only instruction cache. On a miss it requests the line from the MMU.
// It steers each MMU beat into the even/odd instruction banks (bank0 = even words, bank1 = odd words) of the victim way.
// It then writes the new tag and pulses done. Sits between the cache lookup/LRU logic and the MMU.

---
 rtl/ro_cache_refill_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ro_cache_refill_ctrl.sv
// Instruction-cache line refill sequencer: requests a line from the MMU, steers beats
// into the even/odd banks of the victim way, then writes the tag and pulses done.
module ro_cache_refill_ctrl #(
  parameter int ADDR_LENGTH = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int LINE_WORDS  = 16,
  parameter int SETS        = 16,
  parameter int WAYS        = 4,
  localparam int WB    = $clog2(LINE_WORDS),
  localparam int OFF   = WB + 2,
  localparam int SETB  = $clog2(SETS),
  localparam int TAGB  = ADDR_LENGTH - OFF - SETB,
  localparam int WAYB  = $clog2(WAYS),
  localparam int BADDR = WAYB + SETB + WB - 1
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic                   i_miss,
  input  logic [ADDR_LENGTH-1:0] i_miss_addr,
  input  logic [WAYB-1:0]        i_victim_way,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_mmu_req,
  output logic [ADDR_LENGTH-1:0] o_mmu_addr,
  input  logic                   i_mmu_ack,
  input  logic                   i_mmu_we,
  input  logic [INSTR_SIZE-1:0]  i_mmu_data,
  output logic                   o_bank0_wr,
  output logic                   o_bank1_wr,
  output logic [BADDR-1:0]       o_bank0_addr,
  output logic [BADDR-1:0]       o_bank1_addr,
  output logic [INSTR_SIZE-1:0]  o_bank0_din,
  output logic [INSTR_SIZE-1:0]  o_bank1_din,
  output logic                   o_tag_wr,
  output logic [SETB-1:0]        o_tag_addr,
  output logic [WAYB-1:0]        o_tag_way,
  output logic [TAGB-1:0]        o_tag_din,
  output logic                   o_tag_valid,
  output logic                   o_proto_err
);

  localparam logic [ADDR_LENGTH-1:0] LINE_MASK =
    ~(ADDR_LENGTH'((64'd1 << OFF) - 64'd1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_TAG,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [WB-1:0]          r_cnt;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [WAYB-1:0]        r_way;
  logic                   r_busy;
  logic                   r_req;
  logic                   r_tag_wr;
  logic                   r_tag_valid;
  logic                   r_done;
  logic                   r_aborted;
  logic                   r_proto_err;

  logic                   w_beat;
  logic [BADDR-1:0]       w_baddr;

  // Bank writes follow the beat in the same cycle; counter LSB picks the bank.
  assign w_beat  = (r_state == S_FILL) && i_mmu_we;
  assign w_baddr = {r_way, r_addr[OFF+SETB-1:OFF], r_cnt[WB-1:1]};

  assign o_bank0_wr   = w_beat && !r_cnt[0];
  assign o_bank1_wr   = w_beat &&  r_cnt[0];
  assign o_bank0_addr = w_baddr;
  assign o_bank1_addr = w_baddr;
  assign o_bank0_din  = i_mmu_data;
  assign o_bank1_din  = i_mmu_data;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mmu_req   = r_req;
  assign o_mmu_addr  = r_addr & LINE_MASK;
  assign o_tag_wr    = r_tag_wr;
  assign o_tag_addr  = r_addr[OFF+SETB-1:OFF];
  assign o_tag_way   = r_way;
  assign o_tag_din   = r_addr[ADDR_LENGTH-1:OFF+SETB];
  assign o_tag_valid = r_tag_valid;
  assign o_proto_err = r_proto_err;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_way       <= '0;
      r_busy      <= 1'b0;
      r_req       <= 1'b0;
      r_tag_wr    <= 1'b0;
      r_tag_valid <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_tag_wr    <= 1'b0;
      r_tag_valid <= 1'b0;
      r_done      <= 1'b0;
      if (i_mmu_we && (r_state != S_FILL)) r_proto_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_miss) begin
            r_addr    <= i_miss_addr;
            r_way     <= i_victim_way;
            r_busy    <= 1'b1;
            r_req     <= 1'b1;
            r_aborted <= 1'b0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_abort) begin
            r_req     <= 1'b0;
            r_aborted <= 1'b1;
            r_tag_wr  <= 1'b1;
            r_state   <= S_TAG;
          end else if (i_mmu_ack) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_mmu_we) r_cnt <= r_cnt + WB'(1);
          // A beat coinciding with abort is still written; the tag then goes invalid.
          if (i_abort) begin
            r_aborted <= 1'b1;
            r_tag_wr  <= 1'b1;
            r_state   <= S_TAG;
          end else if (i_mmu_we && (r_cnt == WB'(LINE_WORDS - 1))) begin
            r_tag_wr    <= 1'b1;
            r_tag_valid <= 1'b1;
            r_state     <= S_TAG;
          end
        end
        S_TAG: begin
          r_done  <= !r_aborted;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
